// File: rtl/mcu_el2_lsu_ecc_nbank.sv
// ---------------------------------------------------------------------------
// mcu_el2_lsu_ecc_nbank
//   Multi-bank DCCM SECDED engine. It checks and corrects read data for each
//   bank and generates ECC for write data. Corrected single-bit errors are
//   queued in a small writeback FIFO so that the fixed word can be scrubbed
//   back into the DCCM. Saturating SEC/DED counters and a sticky flag record
//   any dropped writeback.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   ecc_disable     bypass checking: data passes raw, no errors, no pushes
//   rd_valid/addr/data/ecc   per-bank read check request and raw codeword
//   rsp_valid/data/sec/ded   per-bank check result (M- or R-stage)
//   wr_data / wr_ecc         per-bank write data and its generated ECC
//   wb_valid/ready/bank/addr/data/ecc   writeback FIFO head handshake
//   cnt_clr         synchronous clear of counters and overflow flag
//   sec_count, ded_count, wb_overflow   error statistics
// ---------------------------------------------------------------------------
module mcu_el2_lsu_ecc_nbank #(
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned WB_DEPTH   = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned PIPE_STAGE = 1,
    // P = smallest value with 2^P >= DATA_WIDTH + P + 1
    localparam int unsigned ECC_P     = (DATA_WIDTH <= 1)   ? 2 :
                                        (DATA_WIDTH <= 4)   ? 3 :
                                        (DATA_WIDTH <= 11)  ? 4 :
                                        (DATA_WIDTH <= 26)  ? 5 :
                                        (DATA_WIDTH <= 57)  ? 6 :
                                        (DATA_WIDTH <= 120) ? 7 :
                                        (DATA_WIDTH <= 247) ? 8 : 9,
    localparam int unsigned ECC_WIDTH = ECC_P + 1,
    localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ecc_disable,
    input  logic [NUM_BANKS-1:0]            rd_valid,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_BANKS*ECC_WIDTH-1:0]  rd_ecc,
    output logic [NUM_BANKS-1:0]            rsp_valid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rsp_data,
    output logic [NUM_BANKS-1:0]            rsp_sec,
    output logic [NUM_BANKS-1:0]            rsp_ded,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_BANKS*ECC_WIDTH-1:0]  wr_ecc,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [BANK_W-1:0]               wb_bank,
    output logic [ADDR_WIDTH-1:0]           wb_addr,
    output logic [DATA_WIDTH-1:0]           wb_data,
    output logic [ECC_WIDTH-1:0]            wb_ecc,
    input  logic                            cnt_clr,
    output logic [CNT_WIDTH-1:0]            sec_count,
    output logic [CNT_WIDTH-1:0]            ded_count,
    output logic                            wb_overflow
);

    localparam int unsigned P      = ECC_P;
    localparam int unsigned CODE_N = DATA_WIDTH + P;
    localparam int unsigned PTR_W  = $clog2(WB_DEPTH);
    localparam int unsigned SUM_W  = CNT_WIDTH + 4;

    // -----------------------------------------------------------------------
    // Code helpers. Data bits occupy the non-power-of-2 codeword positions
    // 1..CODE_N in ascending order; Hamming bit i covers positions with bit i set.
    // -----------------------------------------------------------------------
    function automatic logic [P-1:0] ecc_bits(input logic [DATA_WIDTH-1:0] d);
        logic [P-1:0] h;
        int unsigned  j;
        h = '0;
        j = 0;
        for (int unsigned pos = 1; pos <= CODE_N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int unsigned i = 0; i < P; i++) begin
                    if (pos[i]) h[i] = h[i] ^ d[j];
                end
                j++;
            end
        end
        return h;
    endfunction

    function automatic logic [ECC_WIDTH-1:0] ecc_gen(input logic [DATA_WIDTH-1:0] d);
        logic [P-1:0] h;
        h = ecc_bits(d);
        return {(^d) ^ (^h), h};
    endfunction

    // A syndrome that points at a check-bit position matches no data bit,
    // so the data is returned unchanged.
    function automatic logic [DATA_WIDTH-1:0] ecc_fix(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [P-1:0]          syn);
        logic [DATA_WIDTH-1:0] r;
        int unsigned           j;
        r = d;
        j = 0;
        for (int unsigned pos = 1; pos <= CODE_N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (pos == 32'(syn)) r[j] = ~d[j];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [SUM_W-1:0] popcnt(input logic [NUM_BANKS-1:0] v);
        logic [SUM_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            c = c + SUM_W'(v[i]);
        end
        return c;
    endfunction

    // -----------------------------------------------------------------------
    // Write-side ECC generation
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ecc = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            wr_ecc[b*ECC_WIDTH +: ECC_WIDTH] = ecc_gen(wr_data[b*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // -----------------------------------------------------------------------
    // Check stage
    // -----------------------------------------------------------------------
    logic [NUM_BANKS-1:0]            chk_valid;
    logic [NUM_BANKS-1:0]            chk_sec;
    logic [NUM_BANKS-1:0]            chk_ded;
    logic [NUM_BANKS*DATA_WIDTH-1:0] chk_data;
    logic [DATA_WIDTH-1:0]           chk_d;
    logic [ECC_WIDTH-1:0]            chk_e;
    logic [P-1:0]                    chk_syn;
    logic                            chk_odd;
    logic                            chk_en;

    always_comb begin
        chk_valid = rd_valid;
        chk_sec   = '0;
        chk_ded   = '0;
        chk_data  = '0;
        chk_d     = '0;
        chk_e     = '0;
        chk_syn   = '0;
        chk_odd   = 1'b0;
        chk_en    = 1'b0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            chk_d   = rd_data[b*DATA_WIDTH +: DATA_WIDTH];
            chk_e   = rd_ecc[b*ECC_WIDTH +: ECC_WIDTH];
            chk_syn = ecc_bits(chk_d) ^ chk_e[P-1:0];
            // Overall parity of the received codeword: odd => odd error count
            chk_odd = (^chk_d) ^ (^chk_e);
            chk_en  = rd_valid[b] & ~ecc_disable;
            if (rd_valid[b]) begin
                chk_sec[b] = chk_en & chk_odd;
                chk_ded[b] = chk_en & ~chk_odd & (chk_syn != '0);
                chk_data[b*DATA_WIDTH +: DATA_WIDTH] =
                    (chk_en & chk_odd) ? ecc_fix(chk_d, chk_syn) : chk_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response stage (M-stage passthrough or registered R-stage)
    // -----------------------------------------------------------------------
    logic [NUM_BANKS*ADDR_WIDTH-1:0] rsp_addr;

    generate
        if (PIPE_STAGE != 0) begin : g_pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rsp_valid <= '0;
                    rsp_data  <= '0;
                    rsp_sec   <= '0;
                    rsp_ded   <= '0;
                    rsp_addr  <= '0;
                end else begin
                    rsp_valid <= chk_valid;
                    rsp_data  <= chk_data;
                    rsp_sec   <= chk_sec;
                    rsp_ded   <= chk_ded;
                    rsp_addr  <= rd_addr;
                end
            end
        end else begin : g_comb
            always_comb begin
                rsp_valid = chk_valid;
                rsp_data  = chk_data;
                rsp_sec   = chk_sec;
                rsp_ded   = chk_ded;
                rsp_addr  = rd_addr;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Writeback FIFO
    // -----------------------------------------------------------------------
    logic [BANK_W-1:0]     fifo_bank [WB_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [WB_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        occ;
    logic [PTR_W:0]        free_slots;
    logic [PTR_W:0]        push_cnt;
    logic [NUM_BANKS-1:0]  push_en;
    logic [PTR_W-1:0]      push_slot [NUM_BANKS];
    logic                  push_drop;
    logic                  pop;

    assign wb_valid = (occ != '0);
    assign pop      = wb_valid & wb_ready;

    // Slots are handed out in ascending bank order against the registered
    // occupancy, so a same-cycle pop never makes room and the highest banks
    // are the ones dropped.
    always_comb begin
        free_slots = (PTR_W+1)'(WB_DEPTH) - occ;
        push_cnt   = '0;
        push_en    = '0;
        push_drop  = 1'b0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            push_slot[b] = wr_ptr + push_cnt[PTR_W-1:0];
            if (rsp_sec[b]) begin
                if (push_cnt < free_slots) begin
                    push_en[b] = 1'b1;
                    push_cnt   = push_cnt + (PTR_W+1)'(1);
                end else begin
                    push_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (push_en[b]) begin
                fifo_bank[push_slot[b]] <= BANK_W'(b);
                fifo_addr[push_slot[b]] <= rsp_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
                fifo_data[push_slot[b]] <= rsp_data[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop);
            occ    <= occ + push_cnt - (PTR_W+1)'(pop);
        end
    end

    assign wb_bank = fifo_bank[rd_ptr];
    assign wb_addr = fifo_addr[rd_ptr];
    assign wb_data = fifo_data[rd_ptr];

    always_comb begin
        wb_ecc = ecc_gen(wb_data);
    end

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
    logic [SUM_W-1:0] sec_sum;
    logic [SUM_W-1:0] ded_sum;

    always_comb begin
        sec_sum = SUM_W'(sec_count) + popcnt(rsp_sec);
        ded_sum = SUM_W'(ded_count) + popcnt(rsp_ded);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_count   <= '0;
            ded_count   <= '0;
            wb_overflow <= 1'b0;
        end else if (cnt_clr) begin
            sec_count   <= '0;
            ded_count   <= '0;
            wb_overflow <= 1'b0;
        end else begin
            sec_count <= (|sec_sum[SUM_W-1:CNT_WIDTH]) ? '1 : sec_sum[CNT_WIDTH-1:0];
            ded_count <= (|ded_sum[SUM_W-1:CNT_WIDTH]) ? '1 : ded_sum[CNT_WIDTH-1:0];
            if (push_drop) wb_overflow <= 1'b1;
        end
    end

endmodule
